select_encode: RTL

SELECT_ENCODE -- requirements
Module: select_encode

---
 rtl/select_encode.sv | 130 +++++++++++++
 1 files changed

// File: rtl/select_encode.sv
// select_encode: IR capture, register-field select decode and a write-strobe FSM.
// Optional build macro: R0_BASE_ZERO_EN -- when defined, a base-address read
// (BAout without Rout) of index 0 drives no register, so R0 reads as zero.
module select_encode (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] BusMuxOut,
  input  logic        IRin,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  output logic [15:0] R_in,
  output logic [15:0] R_out,
  output logic [31:0] C_sign_extended,
  output logic [31:0] IR,
  output logic        busy,
  output logic        sel_err,
  output logic [7:0]  wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic [3:0]  r_idx;
  logic [15:0] r_rin;
  logic [15:0] r_rout;
  logic        r_err;
  logic [7:0]  r_cnt;

  logic        w_legal;
  logic [3:0]  w_sel;
  logic [15:0] w_sel_oh;
  logic        w_rd_req;
  logic        w_rd_zero;
  logic        w_latch;
  logic        w_wr_err;
  logic        w_rd_err;

  // exactly one of the three field selects may be high
  assign w_legal  = (Gra ^ Grb ^ Grc) & ~(Gra & Grb & Grc);
  assign w_sel_oh = 16'h0001 << w_sel;
  assign w_rd_req = Rout | BAout;

  // pick the register field of the current IR named by the select lines
  always_comb begin
    w_sel = 4'd0;
    if (Gra)      w_sel = r_ir[26:23];
    else if (Grb) w_sel = r_ir[22:19];
    else if (Grc) w_sel = r_ir[18:15];
  end

`ifdef R0_BASE_ZERO_EN
  // base addressing through R0 means "no base": suppress the drive enable
  assign w_rd_zero = BAout & ~Rout & (w_sel == 4'd0);
`else
  assign w_rd_zero = 1'b0;
`endif

  assign w_latch  = (r_state == S_IDLE) & Rin & w_legal;
  assign w_wr_err = (r_state == S_IDLE) & Rin & ~w_legal;
  assign w_rd_err = w_rd_req & ~w_legal;

  // write FSM next state: one strobe per Rin assertion, hold until Rin drops
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_latch) w_next = S_WRITE;
      S_WRITE: w_next = S_HOLD;
      S_HOLD:  if (!Rin) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state and latched write index; index is frozen once WRITE is entered
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_latch) r_idx <= w_sel;
    end
  end

  // instruction register capture
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_ir <= 32'd0;
    else if (IRin) r_ir <= BusMuxOut;
  end

  // write strobe and counter: issued by the WRITE state, visible next cycle
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_rin <= 16'd0;
      r_cnt <= 8'd0;
    end else if (r_state == S_WRITE) begin
      r_rin <= 16'h0001 << r_idx;
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_rin <= 16'd0;
    end
  end

  // read enables follow the live select; bad selects give no enable
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_rout <= 16'd0;
    else if (w_rd_req && w_legal && !w_rd_zero) r_rout <= w_sel_oh;
    else r_rout <= 16'd0;
  end

  // one error flag covers both write and read select faults in a cycle
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_err <= 1'b0;
    else r_err <= w_wr_err | w_rd_err;
  end

  assign IR              = r_ir;
  assign C_sign_extended = {{13{r_ir[18]}}, r_ir[18:0]};
  assign R_in            = r_rin;
  assign R_out           = r_rout;
  assign busy            = (r_state != S_IDLE);
  assign sel_err         = r_err;
  assign wr_count        = r_cnt;

endmodule
